// File: rtl/vga_scan_generator_pkg.sv
// Shared raster constants and helpers for the VGA scan generator and its axis counters.
// Every raster timing value is derived from the porch/sync/active parameters at elaboration.
package vga_scan_generator_pkg;

    localparam int COORD_W = 12;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } scan_flags_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int count_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running 0..TOTAL-1 counter advanced by enable, with active/sync window decode.
// wrap is high on the enabled cycle that returns the count to zero.
module vga_axis_counter
    import vga_scan_generator_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int ACTIVE     = 640,
    localparam int W         = count_width(TOTAL)
) (
    input  logic         CLOCK_25,
    input  logic         reset,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    // One extra bit so a window edge equal to TOTAL still compares correctly.
    localparam logic [W:0]   ACT_END = (W+1)'(ACTIVE);
    localparam logic [W:0]   SYN_BEG = (W+1)'(SYNC_START);
    localparam logic [W:0]   SYN_END = (W+1)'(SYNC_END);

    logic [W:0] count_x;

    assign count_x   = {1'b0, count};
    assign wrap      = enable && (count == LAST);
    assign in_active = count_x < ACT_END;
    assign in_sync   = (count_x >= SYN_BEG) && (count_x < SYN_END);

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_generator.sv
// VGA raster generator: x/y one cycle after the counters, pins COLOR_LATENCY+1 cycles after x/y.
// Sync and active flags ride a delay line so colour, blanking and syncs change on one edge.
module vga_scan_generator
    import vga_scan_generator_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int COLOR_LATENCY   = 1
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
);

    localparam int H_TOTAL      = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_SYNC_START = sync_start(H_ACTIVE, H_FP);
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = sync_start(V_ACTIVE, V_FP);
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int H_W          = count_width(H_TOTAL);
    localparam int V_W          = count_width(V_TOTAL);
    localparam int DEPTH        = COLOR_LATENCY + 1;

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_wrap, h_act, h_sync;
    logic           v_wrap_unused, v_act, v_sync;

    scan_flags_t    flags [0:DEPTH];
    logic [2:0]     rgb_q;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END),
        .ACTIVE     (H_ACTIVE)
    ) u_h_axis (
        .CLOCK_25  (CLOCK_25),
        .reset     (reset),
        .enable    (1'b1),
        .count     (h_cnt),
        .wrap      (h_wrap),
        .in_active (h_act),
        .in_sync   (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END),
        .ACTIVE     (V_ACTIVE)
    ) u_v_axis (
        .CLOCK_25  (CLOCK_25),
        .reset     (reset),
        .enable    (h_wrap),
        .count     (v_cnt),
        .wrap      (v_wrap_unused),
        .in_active (v_act),
        .in_sync   (v_sync)
    );

    // flags[0] is aligned with x/y; flags[DEPTH] is aligned with the pins.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            frame_tick <= 1'b0;
            rgb_q      <= 3'b000;
            for (int i = 0; i <= DEPTH; i++) begin
                flags[i] <= '0;
            end
        end else begin
            if (h_act && v_act) begin
                x <= COORD_W'(h_cnt) + COORD_W'(1);
                y <= COORD_W'(v_cnt) + COORD_W'(1);
            end else begin
                x <= '0;
                y <= '0;
            end
            frame_tick <= (h_cnt == '0) && (v_cnt == V_W'(V_ACTIVE));
            flags[0]   <= '{active: h_act && v_act, hs: h_sync, vs: v_sync};
            for (int i = 1; i <= DEPTH; i++) begin
                flags[i] <= flags[i-1];
            end
            // color for a slot is valid COLOR_LATENCY cycles after its x/y, i.e. alongside flags[COLOR_LATENCY].
            rgb_q <= flags[COLOR_LATENCY].active ? color : 3'b000;
        end
    end

    assign vga_r = rgb_q[2];
    assign vga_g = rgb_q[1];
    assign vga_b = rgb_q[0];
    assign hsync = (SYNC_ACTIVE_LOW != 0) ? ~flags[DEPTH].hs : flags[DEPTH].hs;
    assign vsync = (SYNC_ACTIVE_LOW != 0) ? ~flags[DEPTH].vs : flags[DEPTH].vs;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench: full-size raster (latency 1, active-low) against a hand-computed vector table, plus two
// small-raster builds (latency 3 active-high, latency 0 active-low) checked every cycle against an index model.
module tb_vga_scan_generator;

    logic        clk;
    logic        reset;
    int          cyc;
    int          checks;
    int          failures;
    bit          chk_en;
    bit          phase1;

    logic [2:0]  color_a, color_b, color_c;
    logic [11:0] xa, ya, xb, yb, xc, yc;
    logic        ra, ga, ba, hsa, vsa, ta;
    logic        rb, gb, bb, hsb, vsb, tb_b;
    logic        rc, gc, bc, hsc, vsc, tc;
    logic [11:0] xb_d1, xb_d2, xb_d3;

    int hsa_low_cnt, blank_bad_cnt, tick_b_cnt, tick_c_cnt, vsb_cnt, vsc_cnt;

    vga_scan_generator u_dut_a (
        .CLOCK_25 (clk), .reset (reset), .color (color_a),
        .x (xa), .y (ya), .vga_r (ra), .vga_g (ga), .vga_b (ba),
        .hsync (hsa), .vsync (vsa), .frame_tick (ta)
    );

    vga_scan_generator #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_ACTIVE_LOW (0), .COLOR_LATENCY (3)
    ) u_dut_b (
        .CLOCK_25 (clk), .reset (reset), .color (color_b),
        .x (xb), .y (yb), .vga_r (rb), .vga_g (gb), .vga_b (bb),
        .hsync (hsb), .vsync (vsb), .frame_tick (tb_b)
    );

    vga_scan_generator #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_ACTIVE_LOW (1), .COLOR_LATENCY (0)
    ) u_dut_c (
        .CLOCK_25 (clk), .reset (reset), .color (color_c),
        .x (xc), .y (yc), .vga_r (rc), .vga_g (gc), .vga_b (bc),
        .hsync (hsc), .vsync (vsc), .frame_tick (tc)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Colour source as a function of column, nonzero for every visible column.
    function automatic logic [2:0] cfun(input logic [11:0] xv);
        int t;
        t = int'(xv);
        if (t == 0) return 3'b000;
        return 3'(((t - 1) % 7) + 1);
    endfunction

    initial begin
        xb_d1 = '0; xb_d2 = '0; xb_d3 = '0;
    end
    always @(posedge clk) begin
        xb_d1 <= xb;
        xb_d2 <= xb_d1;
        xb_d3 <= xb_d2;
    end
    assign color_b = cfun(xb_d3);
    assign color_c = cfun(xc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Small raster (16x10): n edges after release, x/y show slot n-1 and pins show slot n-lat-2.
    function automatic logic [31:0] model(input int n, input int lat, input bit low);
        int k, h, v;
        logic [11:0] ex, ey;
        logic [2:0]  rgb;
        logic        hs, vs, tk;
        ex = '0; ey = '0; rgb = '0; hs = 1'b0; vs = 1'b0; tk = 1'b0;
        k = n - 1;
        if (k >= 0) begin
            h = k % 16;
            v = (k / 16) % 10;
            if (h < 8 && v < 6) begin
                ex = 12'(h + 1);
                ey = 12'(v + 1);
            end
            tk = (h == 0 && v == 6);
        end
        k = n - lat - 2;
        if (k >= 0) begin
            h = k % 16;
            v = (k / 16) % 10;
            if (h < 8 && v < 6) rgb = cfun(12'(h + 1));
            hs = (h >= 10 && h < 13);
            vs = (v >= 7 && v < 9);
        end
        if (low) begin
            hs = ~hs;
            vs = ~vs;
        end
        return {2'b00, ex, ey, rgb, hs, vs, tk};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check($sformatf("b_cycle_%0d", cyc), {2'b00, xb, yb, rb, gb, bb, hsb, vsb, tb_b}, model(cyc, 3, 1'b0));
            check($sformatf("c_cycle_%0d", cyc), {2'b00, xc, yc, rc, gc, bc, hsc, vsc, tc}, model(cyc, 0, 1'b1));
            if (phase1) begin
                if (cyc >= 3 && cyc <= 802 && !hsa) hsa_low_cnt++;
                if (cyc >= 643 && cyc <= 802 && {ra, ga, ba} != 3'b000) blank_bad_cnt++;
                if (cyc >= 1 && cyc <= 1440 && tb_b) tick_b_cnt++;
                if (cyc >= 1 && cyc <= 1440 && tc) tick_c_cnt++;
                if (cyc >= 5 && cyc <= 1444 && vsb) vsb_cnt++;
                if (cyc >= 2 && cyc <= 1441 && !vsc) vsc_cnt++;
            end
        end
    end

    typedef struct {
        int          n;
        logic [11:0] x;
        logic [11:0] y;
        logic [2:0]  rgb;
        logic        hs;
        logic        vs;
        logic        tk;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int guard;
        checks = 0; failures = 0; chk_en = 0; phase1 = 1;
        hsa_low_cnt = 0; blank_bad_cnt = 0; tick_b_cnt = 0; tick_c_cnt = 0; vsb_cnt = 0; vsc_cnt = 0;

        // Full-size raster, colour 101: x/y at edge n show slot n-1, pins show slot n-3.
        tbl[0]  = '{1,   12'd1,   12'd1, 3'b000, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{2,   12'd2,   12'd1, 3'b000, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{3,   12'd3,   12'd1, 3'b101, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{640, 12'd640, 12'd1, 3'b101, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{641, 12'd0,   12'd0, 3'b101, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{642, 12'd0,   12'd0, 3'b101, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{643, 12'd0,   12'd0, 3'b000, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{658, 12'd0,   12'd0, 3'b000, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{659, 12'd0,   12'd0, 3'b000, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{754, 12'd0,   12'd0, 3'b000, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{755, 12'd0,   12'd0, 3'b000, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{800, 12'd0,   12'd0, 3'b000, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{801, 12'd1,   12'd2, 3'b000, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{803, 12'd3,   12'd2, 3'b101, 1'b1, 1'b1, 1'b0};

        reset   = 1'b1;
        color_a = 3'b101;
        @(posedge clk);
        chk_en = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("a_reset_state", {2'b00, xa, ya, ra, ga, ba, hsa, vsa, ta},
              {2'b00, 12'd0, 12'd0, 3'b000, 1'b1, 1'b1, 1'b0});
        reset = 1'b0;

        guard = 0;
        for (int i = 0; i < 14; i++) begin
            while (cyc < tbl[i].n && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("a_vec_n%0d", tbl[i].n), {2'b00, xa, ya, ra, ga, ba, hsa, vsa, ta},
                  {2'b00, tbl[i].x, tbl[i].y, tbl[i].rgb, tbl[i].hs, tbl[i].vs, tbl[i].tk});
        end

        // Counters hold h=700, v=1 here; pins show h=697, inside hsync.
        while (cyc < 1500 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_budget", guard >= 5000, 0);
        check("a_hsync_before_reset", hsa, 1'b0);
        phase1 = 0;
        reset  = 1'b1;
        @(negedge clk);
        check("a_midreset_xy", {xa, ya}, 24'd0);
        check("a_midreset_pins", {ra, ga, ba, hsa, vsa, ta}, {3'b000, 1'b1, 1'b1, 1'b0});
        reset = 1'b0;
        @(negedge clk);
        check("a_restart_xy", {xa, ya}, {12'd1, 12'd1});
        check("a_restart_hsync", hsa, 1'b1);
        repeat (2) @(negedge clk);
        check("a_restart_first_pixel", {ra, ga, ba}, 3'b101);

        check("a_hsync_width", hsa_low_cnt, 96);
        check("a_blank_rgb_nonzero", blank_bad_cnt, 0);
        check("b_frame_ticks", tick_b_cnt, 9);
        check("c_frame_ticks", tick_c_cnt, 9);
        check("b_vsync_cycles", vsb_cnt, 288);
        check("c_vsync_cycles", vsc_cnt, 288);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
